// File: rtl/sst_dump_reader.sv
// Bulk reader for the save-state address space: issues pipelined reads with
// FIFO credit flow control and streams the returned bytes over valid/ready.
module sst_dump_reader #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned LEN_W      = 14,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [LEN_W-1:0]              len,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [7:0]                    rd_data,
    output logic [7:0]                    dout,
    output logic                          dout_vld,
    input  logic                          dout_rdy,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = LW + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    issue_cnt;
    logic [LEN_W-1:0]    pop_cnt;
    logic [LEN_W-1:0]    len_eff;
    logic [RD_LAT-1:0]   vld_sr;
    logic [CW-1:0]       inflight;
    logic                credit_ok;
    logic                push;
    logic                pop;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++)
            inflight = inflight + CW'(vld_sr[i]);
    end

    // Reads already in flight hold a FIFO slot, so a push can never find it full.
    assign credit_ok = (CW'(level) + inflight) < CW'(FIFO_DEPTH);
    assign rd_en     = (state == RUN) && (issue_cnt != '0) && credit_ok;
    assign rd_addr   = addr;
    assign push      = vld_sr[RD_LAT-1];
    assign dout_vld  = (level != '0);
    assign pop       = dout_vld && dout_rdy;
    assign dout      = mem[rptr];
    assign len_eff   = (len > MAX_LEN) ? MAX_LEN : len;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                if (pop && busy)
                    pop_cnt <= pop_cnt - LEN_W'(1);
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (len == '0) begin
                                state <= FIN;
                            end else begin
                                addr      <= base_addr;
                                issue_cnt <= len_eff;
                                pop_cnt   <= len_eff;
                                busy      <= 1'b1;
                                state     <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (rd_en) begin
                            addr      <= addr + ADDR_W'(1);
                            issue_cnt <= issue_cnt - LEN_W'(1);
                        end
                        if (issue_cnt == '0)
                            state <= DRAIN;
                    end
                    DRAIN: begin
                        if (pop_cnt == '0) begin
                            state <= FIN;
                            busy  <= 1'b0;
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_sr <= '0;
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            mem    <= '{default: '0};
        end else if (abort) begin
            vld_sr <= '0;
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | RD_LAT'(rd_en);
            if (push) begin
                mem[wptr] <= rd_data;
                wptr      <= wptr + PW'(1);
            end
            if (pop)
                rptr <= rptr + PW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (!push && pop)
                level <= level - LW'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!sys_rst_n)
        (push && !abort) |-> (level != LW'(FIFO_DEPTH)));

endmodule
